dbus_timer_slave: RTL and testbench

Programmable down-counter timer peripheral that answers the team's 8-bit data-bus master as a register-mapped responder. It decodes single-cycle Wr strobes into a small control/status register bank and returns read data on the same address phase. A prescaled down-counter drives a sticky terminal-count flag and a level interrupt toward the system interrupt logic.

---
 rtl/dbus_timer_slave.sv | 129 ++++++++++++
 tb/tb_dbus_timer_slave.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_timer_slave.sv
// Register-mapped down-counter timer on the 8-bit data bus.
// A prescaler produces ticks that decrement COUNT. An expiry at COUNT==0
// sets a sticky TC flag, and a second expiry while TC is still set also
// sets OVR. Irq is the registered AND of TC and IE.
module dbus_timer_slave #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 8'hA5
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [DATA_WIDTH-1:0] Din,
  output logic [DATA_WIDTH-1:0] Dout,
  input  logic                  Wr,
  output logic                  Irq
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_PRESC  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LOAD   = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_COUNT  = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ID     = ADDR_WIDTH'(5);

  logic                  en, auto_rl, ie;
  logic [DATA_WIDTH-1:0] prescale, load, count, pcnt;
  logic                  tc, ovr;

  logic                  wr_ctrl, wr_presc, wr_load, wr_status;
  logic                  tick, tc_set;
  logic                  en_next;
  logic [DATA_WIDTH-1:0] count_next, pcnt_next;
  logic                  tc_next, ovr_next;

  assign wr_ctrl   = Wr && (Addr == ADDR_CTRL);
  assign wr_presc  = Wr && (Addr == ADDR_PRESC);
  assign wr_load   = Wr && (Addr == ADDR_LOAD);
  assign wr_status = Wr && (Addr == ADDR_STATUS);

  // A LOAD write takes over the whole edge: it masks any tick that would
  // otherwise have happened at the same time.
  assign tick   = en && (pcnt == prescale) && !wr_load;
  assign tc_set = tick && (count == '0);

  // Next-state logic for the prescaler, counter, status flags and enable.
  always_comb begin
    pcnt_next  = pcnt;
    count_next = count;
    tc_next    = tc;
    ovr_next   = ovr;
    en_next    = en;

    if (wr_load || (wr_ctrl && Din[0] && !en)) begin
      pcnt_next = '0;
    end else if (en) begin
      pcnt_next = (pcnt == prescale) ? '0 : pcnt + 1'b1;
    end

    if (wr_load) begin
      count_next = Din;
    end else if (tick) begin
      if (count != '0) begin
        count_next = count - 1'b1;
      end else if (auto_rl) begin
        count_next = load;
      end
    end

    // The W1C clear is applied first, so a flag being set on the same edge wins.
    if (wr_status && Din[0]) tc_next  = 1'b0;
    if (wr_status && Din[1]) ovr_next = 1'b0;
    if (tc_set) begin
      tc_next = 1'b1;
      if (tc) ovr_next = 1'b1;
    end

    // A CTRL write overrides the one-shot enable clear.
    if (wr_ctrl) begin
      en_next = Din[0];
    end else if (tc_set && !auto_rl) begin
      en_next = 1'b0;
    end
  end

  // Register bank, timer state and the registered interrupt.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      en       <= 1'b0;
      auto_rl  <= 1'b0;
      ie       <= 1'b0;
      prescale <= '0;
      load     <= '0;
      count    <= '0;
      pcnt     <= '0;
      tc       <= 1'b0;
      ovr      <= 1'b0;
      Irq      <= 1'b0;
    end else begin
      en    <= en_next;
      count <= count_next;
      pcnt  <= pcnt_next;
      tc    <= tc_next;
      ovr   <= ovr_next;
      Irq   <= tc & ie;
      if (wr_ctrl) begin
        auto_rl <= Din[1];
        ie      <= Din[2];
      end
      if (wr_presc) prescale <= Din;
      if (wr_load)  load     <= Din;
    end
  end

  // Combinational read mux with no side effects.
  always_comb begin
    Dout = '0;
    case (Addr)
      ADDR_CTRL:   Dout = {{(DATA_WIDTH-3){1'b0}}, ie, auto_rl, en};
      ADDR_PRESC:  Dout = prescale;
      ADDR_LOAD:   Dout = load;
      ADDR_COUNT:  Dout = count;
      ADDR_STATUS: Dout = {{(DATA_WIDTH-2){1'b0}}, ovr, tc};
      ADDR_ID:     Dout = ID_VALUE;
      default:     Dout = '0;
    endcase
  end

endmodule

// File: tb/tb_dbus_timer_slave.sv
// Scoreboard bench for dbus_timer_slave. The driver issues one bus cycle
// per clock and queues the expected Dout/Irq. The monitor compares those
// values against the DUT in the middle of the low clock phase.
module tb_dbus_timer_slave;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [7:0] Addr = 8'h00;
  logic [7:0] Din = 8'h00;
  logic [7:0] Dout;
  logic       Wr = 1'b0;
  logic       Irq;

  dbus_timer_slave #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .ID_VALUE(8'hA5)) dut (
    .Clk(Clk), .Rst(Rst), .Addr(Addr), .Din(Din), .Dout(Dout), .Wr(Wr), .Irq(Irq)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] dout;
    logic       irq;
    string      name;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state, tracked as named quantities.
  logic       m_en, m_auto, m_ie, m_tc, m_ovr, m_irq;
  logic [7:0] m_p, m_load, m_count, m_pcnt;

  function automatic logic [7:0] model_read(input logic [7:0] a);
    case (a)
      8'h00:   return {5'b0, m_ie, m_auto, m_en};
      8'h01:   return m_p;
      8'h02:   return m_load;
      8'h03:   return m_count;
      8'h04:   return {6'b0, m_ovr, m_tc};
      8'h05:   return 8'hA5;
      default: return 8'h00;
    endcase
  endfunction

  // Apply one clock edge to the model.
  task automatic model_step(input logic rst, input logic wr, input logic [7:0] a,
                            input logic [7:0] d);
    bit   w_ctrl, w_p, w_load, w_stat, tick, expire, en_in, tc_in, ovr_in;
    logic [7:0] cnt_in, pc_in;
    if (rst) begin
      {m_en, m_auto, m_ie, m_tc, m_ovr, m_irq} = '0;
      m_p = 0; m_load = 0; m_count = 0; m_pcnt = 0;
      return;
    end
    w_ctrl = wr && a == 8'h00;
    w_p    = wr && a == 8'h01;
    w_load = wr && a == 8'h02;
    w_stat = wr && a == 8'h04;
    tick   = m_en && (m_pcnt == m_p) && !w_load;
    expire = tick && (m_count == 0);
    en_in = m_en; tc_in = m_tc; ovr_in = m_ovr; cnt_in = m_count; pc_in = m_pcnt;
    m_irq = m_tc & m_ie;
    // Prescaler: restarts on LOAD write or enable rising, else free-runs while enabled.
    if (w_load || (w_ctrl && d[0] && !en_in)) m_pcnt = 0;
    else if (en_in) m_pcnt = (pc_in == m_p) ? 8'd0 : pc_in + 8'd1;
    // Counter.
    if (w_load) m_count = d;
    else if (tick) m_count = (cnt_in != 0) ? cnt_in - 8'd1 : (m_auto ? m_load : 8'd0);
    // Sticky flags: clear-by-write first, expiry set overrides.
    m_tc  = (tc_in  && !(w_stat && d[0])) || expire;
    m_ovr = (ovr_in && !(w_stat && d[1])) || (expire && tc_in);
    // Control.
    if (w_ctrl) begin
      m_en = d[0]; m_auto = d[1]; m_ie = d[2];
    end else if (expire && !m_auto) begin
      m_en = 1'b0;
    end
    if (w_p) m_p = d;
    if (w_load) m_load = d;
  endtask

  // One bus cycle. chk: 0 = no check, 1 = check against the model, 2 = check against constants.
  task automatic cycle(input logic rst, input logic wr, input logic [7:0] a, input logic [7:0] d,
                       input int chk, input logic [7:0] cd, input logic ci, input string nm);
    exp_t e;
    @(negedge Clk);
    Rst = rst; Wr = wr; Addr = a; Din = d;
    if (chk != 0) begin
      e.addr = a;
      e.name = nm;
      if (chk == 2) begin
        e.dout = cd; e.irq = ci;
      end else begin
        e.dout = model_read(a); e.irq = m_irq;
      end
      sbq.push_back(e);
    end
    model_step(rst, wr, a, d);
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    cycle(1'b0, 1'b1, a, d, 1, 8'h00, 1'b0, "write");
  endtask

  task automatic rd(input logic [7:0] a);
    cycle(1'b0, 1'b0, a, 8'h00, 1, 8'h00, 1'b0, "read");
  endtask

  task automatic rd_const(input logic [7:0] a, input logic [7:0] v, input logic irq,
                          input string nm);
    cycle(1'b0, 1'b0, a, 8'h00, 2, v, irq, nm);
  endtask

  // Monitor: compare one queued expectation per cycle.
  always @(negedge Clk) begin
    #2;
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      n_vec++;
      if (Dout !== mon_e.dout || Irq !== mon_e.irq) begin
        n_err++;
        $display("FAIL %s: addr=%02h Dout=%02h want %02h Irq=%0b want %0b at %0t",
                 mon_e.name, mon_e.addr, Dout, mon_e.dout, Irq, mon_e.irq, $time);
      end
    end
  end

  // Stimulus.
  initial begin
    logic [7:0] ra, rdin;
    logic       rw, rr;
    int         budget;

    cycle(1'b1, 1'b0, 8'h00, 8'h00, 0, 8'h00, 1'b0, "reset");
    for (int i = 0; i < 7; i++)
      rd_const(8'(i), (i == 5) ? 8'hA5 : 8'h00, 1'b0, "reset_read");

    // One-shot: P=0, N=3, CTRL=EN|IE.
    wr_reg(8'h01, 8'h00);
    wr_reg(8'h02, 8'h03);
    wr_reg(8'h00, 8'h05);
    rd_const(8'h03, 8'h03, 1'b0, "os_count3");
    rd_const(8'h03, 8'h02, 1'b0, "os_count2");
    rd_const(8'h03, 8'h01, 1'b0, "os_count1");
    rd_const(8'h03, 8'h00, 1'b0, "os_count0");
    rd_const(8'h04, 8'h01, 1'b0, "os_tc");
    rd_const(8'h00, 8'h04, 1'b1, "os_ctrl_irq");
    rd_const(8'h03, 8'h00, 1'b1, "os_hold0");

    // Auto-reload: P=1, N=2, CTRL=EN|AUTO, W1C on the TC edge, then overrun.
    wr_reg(8'h00, 8'h00);
    wr_reg(8'h04, 8'h03);
    wr_reg(8'h01, 8'h01);
    wr_reg(8'h02, 8'h02);
    wr_reg(8'h00, 8'h03);
    for (int i = 0; i < 5; i++) rd(8'h03);
    wr_reg(8'h04, 8'h01);
    rd_const(8'h04, 8'h01, 1'b0, "w1c_set_wins");
    for (int i = 0; i < 8; i++) rd((i % 2 == 0) ? 8'h03 : 8'h04);
    rd_const(8'h04, 8'h03, 1'b0, "overrun");
    wr_reg(8'h04, 8'h02);
    rd_const(8'h04, 8'h01, 1'b0, "w1c_ovr");

    // LOAD write while running.
    wr_reg(8'h00, 8'h00);
    wr_reg(8'h01, 8'h03);
    wr_reg(8'h02, 8'h05);
    wr_reg(8'h00, 8'h01);
    for (int i = 0; i < 6; i++) rd(8'h03);
    wr_reg(8'h02, 8'h10);
    rd_const(8'h03, 8'h10, 1'b0, "load_while_run");
    for (int i = 0; i < 6; i++) rd(8'h03);

    // Reset mid-count with a simultaneous write.
    wr_reg(8'h01, 8'h00);
    wr_reg(8'h02, 8'h08);
    wr_reg(8'h00, 8'h05);
    for (int i = 0; i < 3; i++) rd(8'h03);
    cycle(1'b1, 1'b1, 8'h02, 8'h77, 1, 8'h00, 1'b0, "rst_with_wr");
    rd_const(8'h03, 8'h00, 1'b0, "rst_count");
    rd_const(8'h02, 8'h00, 1'b0, "rst_load");
    rd_const(8'h00, 8'h00, 1'b0, "rst_ctrl");
    rd_const(8'h04, 8'h00, 1'b0, "rst_status");

    // Randomized traffic checked against the model.
    for (int i = 0; i < 1500; i++) begin
      ra = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 63) == 0) ra = 8'($urandom);
      rw = ($urandom_range(0, 3) == 0);
      rr = ($urandom_range(0, 299) == 0);
      case (ra)
        8'h01:   rdin = 8'($urandom_range(0, 3));
        8'h02:   rdin = 8'($urandom_range(0, 7));
        default: rdin = 8'($urandom);
      endcase
      cycle(rr, rw, ra, rdin, 1, 8'h00, 1'b0, "random");
    end

    @(negedge Clk);
    Wr = 1'b0;
    budget = 20;
    while (sbq.size() > 0 && budget > 0) begin
      @(negedge Clk);
      budget--;
    end
    #3;
    if (sbq.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want finish before it");
    $fatal(1, "watchdog");
  end

endmodule
